// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, condition codes,
// operand-2 shift modes, NZCV bit positions and the control-state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_ORR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_EOR  = 4'h5;
  localparam logic [3:0] OP_MOVI = 4'h6;
  localparam logic [3:0] OP_MOVR = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_LDR  = 4'h9;
  localparam logic [3:0] OP_STR  = 4'hA;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [2:0] SH_NONE = 3'd0;
  localparam logic [2:0] SH_LSR  = 3'd1;
  localparam logic [2:0] SH_LSL  = 3'd2;
  localparam logic [2:0] SH_ROR  = 3'd3;
  localparam logic [2:0] SH_ASR  = 3'd4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Opcodes 0xB..0xE are unassigned.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_STR) || (op == OP_NOP);
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// ARM-style condition evaluation against a committed NZCV value.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_met
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  // Decode the condition field into a pass/fail bit.
  always_comb begin
    o_met = 1'b0;
    case (i_cond)
      COND_EQ: o_met = w_z;
      COND_NE: o_met = ~w_z;
      COND_CS: o_met = w_c;
      COND_CC: o_met = ~w_c;
      COND_MI: o_met = w_n;
      COND_PL: o_met = ~w_n;
      COND_VS: o_met = w_v;
      COND_VC: o_met = ~w_v;
      COND_HI: o_met = w_c & ~w_z;
      COND_LS: o_met = ~w_c | w_z;
      COND_GE: o_met = (w_n == w_v);
      COND_LT: o_met = (w_n != w_v);
      COND_GT: o_met = ~w_z & (w_n == w_v);
      COND_LE: o_met = w_z | (w_n != w_v);
      COND_AL: o_met = 1'b1;
      default: o_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq_n.sv
// Clocked, conditionally-executed ALU with valid/ready handshakes, an NZCV
// flags register, an iterative shift-add multiplier and an output hold buffer.
module alu_seq_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       OPCODE,
  input  logic [3:0]       COND,
  input  logic             S,
  input  logic [2:0]       SHIFT_CTRL,
  input  logic [SHW-1:0]   SHAMT,
  input  logic [IMM_W-1:0] IM_VAL,
  input  logic [WIDTH-1:0] SR1,
  input  logic [WIDTH-1:0] SR2,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             WB_EN,
  output logic             CND_MET,
  output logic             ILLEGAL,
  output logic [3:0]       NZCV
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t r_state, w_state_nxt;

  logic [3:0]         r_nzcv;
  logic [WIDTH-1:0]   r_result;
  logic               r_wb_en;
  logic               r_cnd_met;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_mul_s;

  logic               w_met;
  logic               w_accept;
  logic               w_legal;
  logic               w_exec;
  logic               w_is_mul;
  logic               w_set_flags;
  logic [SHW-1:0]     w_rot_amt;
  logic [WIDTH-1:0]   w_op2;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic               w_alu_wb;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_mul_done;

  alu_cond_eval u_cond (
    .i_cond (COND),
    .i_nzcv (r_nzcv),
    .o_met  (w_met)
  );

  assign IN_READY  = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & OUT_READY);
  assign w_accept  = IN_VALID & IN_READY;
  assign OUT_VALID = (r_state == ST_HOLD);
  assign RESULT    = r_result;
  assign WB_EN     = r_wb_en;
  assign CND_MET   = r_cnd_met;
  assign ILLEGAL   = r_illegal;
  assign NZCV      = r_nzcv;

  // Instruction qualification: illegal, failed-condition and NOP all retire as bubbles.
  assign w_legal     = op_legal(OPCODE) & (SHIFT_CTRL <= SH_ASR);
  assign w_exec      = w_legal & w_met & (OPCODE != OP_NOP);
  assign w_is_mul    = w_exec & (OPCODE == OP_MUL);
  assign w_set_flags = w_exec & (S | (OPCODE == OP_CMP)) &
                       (OPCODE != OP_LDR) & (OPCODE != OP_STR) & (OPCODE != OP_MUL);

  // Rotation is taken modulo WIDTH so non-power-of-two widths still wrap.
  assign w_rot_amt = SHW'(int'(SHAMT) % WIDTH);

  // Operand-2 barrel shifter; a zero amount leaves SR2 untouched in every mode.
  always_comb begin
    w_op2 = SR2;
    case (SHIFT_CTRL)
      SH_LSR: w_op2 = SR2 >> SHAMT;
      SH_LSL: w_op2 = SR2 << SHAMT;
      SH_ROR: begin
        if (w_rot_amt != '0)
          w_op2 = (SR2 >> w_rot_amt) | (SR2 << (WIDTH - int'(w_rot_amt)));
      end
      SH_ASR: w_op2 = $unsigned($signed(SR2) >>> SHAMT);
      default: w_op2 = SR2;
    endcase
  end

  assign w_add = {1'b0, SR1} + {1'b0, w_op2};
  assign w_sub = {1'b0, SR1} + {1'b0, ~w_op2} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle result, carry/overflow and writeback enable.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_wb  = 1'b1;
    case (OPCODE)
      OP_ADD: begin
        w_alu_res = w_add[WIDTH-1:0];
        w_alu_c   = w_add[WIDTH];
        w_alu_v   = (SR1[WIDTH-1] == w_op2[WIDTH-1]) & (w_add[WIDTH-1] != SR1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_alu_res = w_sub[WIDTH-1:0];
        w_alu_c   = w_sub[WIDTH];
        w_alu_v   = (SR1[WIDTH-1] != w_op2[WIDTH-1]) & (w_sub[WIDTH-1] != SR1[WIDTH-1]);
        w_alu_wb  = (OPCODE != OP_CMP);
      end
      OP_ORR:  w_alu_res = SR1 | w_op2;
      OP_AND:  w_alu_res = SR1 & w_op2;
      OP_EOR:  w_alu_res = SR1 ^ w_op2;
      OP_MOVI: w_alu_res = WIDTH'(IM_VAL);
      OP_MOVR: w_alu_res = w_op2;
      OP_LDR:  w_alu_res = SR1;
      OP_STR:  w_alu_res = w_op2;
      default: begin
        w_alu_res = '0;
        w_alu_wb  = 1'b0;
      end
    endcase
  end

  // Shift-add step: the upper half accumulates, the lower half holds the remaining multiplier bits.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_acc_nxt  = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_mul_done = (r_cnt == CNT_LAST);

  // Control state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; the multiplier spends one extra cycle after the last step to commit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_is_mul ? ST_MUL : ST_HOLD;
      end
      ST_MUL: begin
        if (w_mul_done) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_accept)       w_state_nxt = w_is_mul ? ST_MUL : ST_HOLD;
        else if (OUT_READY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result, flags and multiplier registers; held untouched in HOLD until the next acceptance.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_nzcv    <= '0;
      r_result  <= '0;
      r_wb_en   <= 1'b0;
      r_cnd_met <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mul_s   <= 1'b0;
    end else if (r_state == ST_MUL) begin
      if (!w_mul_done) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_result  <= r_acc[WIDTH-1:0];
        r_wb_en   <= 1'b1;
        r_cnd_met <= 1'b1;
        r_illegal <= 1'b0;
        r_cnt     <= '0;
        if (r_mul_s)
          r_nzcv <= {r_acc[WIDTH-1], (r_acc[WIDTH-1:0] == '0), 1'b0, (|r_acc[2*WIDTH-1:WIDTH])};
      end
    end else if (w_accept) begin
      r_cnd_met <= w_met;
      r_illegal <= ~w_legal;
      if (w_is_mul) begin
        r_mcand <= SR1;
        r_acc   <= {{WIDTH{1'b0}}, w_op2};
        r_cnt   <= '0;
        r_mul_s <= S;
        r_wb_en <= 1'b0;
      end else if (w_exec) begin
        r_result <= w_alu_res;
        r_wb_en  <= w_alu_wb;
        if (w_set_flags)
          r_nzcv <= {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
      end else begin
        r_result <= '0;
        r_wb_en  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Scoreboard bench for alu_seq_n at WIDTH=32: expected results are queued at
// acceptance and compared when the DUT hands a result downstream.
module tb_alu_seq_n;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [3:0]  OPCODE;
  logic [3:0]  COND;
  logic        S;
  logic [2:0]  SHIFT_CTRL;
  logic [4:0]  SHAMT;
  logic [15:0] IM_VAL;
  logic [31:0] SR1;
  logic [31:0] SR2;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic        WB_EN;
  logic        CND_MET;
  logic        ILLEGAL;
  logic [3:0]  NZCV;

  alu_seq_n #(.WIDTH(32), .IMM_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .COND(COND), .S(S), .SHIFT_CTRL(SHIFT_CTRL), .SHAMT(SHAMT),
    .IM_VAL(IM_VAL), .SR1(SR1), .SR2(SR2), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .RESULT(RESULT), .WB_EN(WB_EN), .CND_MET(CND_MET),
    .ILLEGAL(ILLEGAL), .NZCV(NZCV)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic        wb;
    logic        met;
    logic        ill;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_nzcv;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_out   = 0;
  bit         rnd_done;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One bit position per iteration, so the reference is independent of barrel-shift operators.
  function automatic logic [31:0] shift_ref(input logic [2:0] m, input logic [4:0] amt, input logic [31:0] x);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < int'(amt); i++) begin
      case (m)
        3'd1: y = {1'b0, y[31:1]};
        3'd2: y = {y[30:0], 1'b0};
        3'd3: y = {y[0], y[31:1]};
        3'd4: y = {y[31], y[31:1]};
        default: y = y;
      endcase
    end
    return y;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [3:0] cond, input logic s,
                                 input logic [2:0] sh, input logic [4:0] amt, input logic [15:0] imm,
                                 input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    exp_t e;
    logic [31:0] b2, r;
    logic [63:0] w;
    logic legal, cy, v;
    legal = ((op <= 4'd10) || (op == 4'd15)) && (sh <= 3'd4);
    b2 = shift_ref(sh, amt, b);
    e.met = cond_ok(cond, f);
    e.ill = !legal;
    e.nzcv = f;
    e.res = 32'h0;
    e.wb = 1'b0;
    if (legal && e.met && op != 4'd15) begin
      cy = 1'b0; v = 1'b0; r = 32'h0; e.wb = 1'b1;
      case (op)
        4'd0: begin
          w = 64'(a) + 64'(b2); r = w[31:0]; cy = w[32];
          v = (a[31] == b2[31]) && (r[31] != a[31]);
        end
        4'd1, 4'd8: begin
          r = a - b2; cy = (a >= b2);
          v = (a[31] != b2[31]) && (r[31] != a[31]);
          if (op == 4'd8) e.wb = 1'b0;
        end
        4'd2: begin
          w = 64'(a) * 64'(b2); r = w[31:0]; v = (w[63:32] != 32'h0);
        end
        4'd3:  r = a | b2;
        4'd4:  r = a & b2;
        4'd5:  r = a ^ b2;
        4'd6:  r = {16'h0, imm};
        4'd7:  r = b2;
        4'd9:  r = a;
        4'd10: r = b2;
        default: r = 32'h0;
      endcase
      e.res = r;
      if ((s || op == 4'd8) && op != 4'd9 && op != 4'd10)
        e.nzcv = {r[31], (r == 32'h0), cy, v};
    end
    return e;
  endfunction

  // Presents one instruction, waits (bounded) for acceptance, queues the expected result.
  task automatic send(input logic [3:0] op, input logic [3:0] cond, input logic s, input logic [2:0] sh,
                      input logic [4:0] amt, input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    OPCODE = op; COND = cond; S = s; SHIFT_CTRL = sh; SHAMT = amt; IM_VAL = imm; SR1 = a; SR2 = b;
    IN_VALID = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (IN_READY) break;
      n++;
      if (n > 200) begin
        chk_eq("accept_timeout", IN_READY, 1);
        IN_VALID = 1'b0;
        return;
      end
    end
    e = model(op, cond, s, sh, amt, imm, a, b, m_nzcv);
    m_nzcv = e.nzcv;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  // Compare whatever the DUT hands over on the coming edge.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && OUT_VALID && OUT_READY) begin
      if (sb_q.size() == 0) begin
        chk_eq("spurious_out", OUT_VALID, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk_eq($sformatf("res#%0d", n_out), RESULT, e.res);
        chk_eq($sformatf("wb#%0d", n_out), WB_EN, e.wb);
        chk_eq($sformatf("met#%0d", n_out), CND_MET, e.met);
        chk_eq($sformatf("ill#%0d", n_out), ILLEGAL, e.ill);
        chk_eq($sformatf("nzcv#%0d", n_out), NZCV, e.nzcv);
        n_out++;
      end
    end
  end

  initial begin
    int lat, seen, qn;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    RESET = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    OPCODE = 4'hF; COND = 4'hE; S = 1'b0; SHIFT_CTRL = 3'd0; SHAMT = 5'd0; IM_VAL = 16'h0;
    SR1 = 32'h0; SR2 = 32'h0; m_nzcv = 4'h0; rnd_done = 1'b0;

    repeat (3) @(negedge CLK);
    chk_eq("rst_out_valid", OUT_VALID, 0);
    chk_eq("rst_nzcv", NZCV, 0);
    chk_eq("rst_result", RESULT, 0);
    chk_eq("rst_wb_en", WB_EN, 0);
    chk_eq("rst_cnd_met", CND_MET, 0);
    chk_eq("rst_illegal", ILLEGAL, 0);
    chk_eq("rst_in_ready", IN_READY, 1);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Signed overflow on ADD, with a direct latency-1 check.
    send(4'h0, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1);
    @(negedge CLK);
    chk_eq("lat1_valid", OUT_VALID, 1);
    chk_eq("lat1_result", RESULT, 32'h80000000);
    chk_eq("lat1_nzcv", NZCV, 4'b1001);
    @(posedge CLK); #1;

    send(4'h8, 4'hE, 1'b0, 3'd0, 5'd0, 16'h0, 32'd5, 32'd5);
    send(4'h1, 4'h0, 1'b0, 3'd0, 5'd0, 16'h0, 32'd9, 32'd4);
    send(4'h8, 4'hE, 1'b0, 3'd0, 5'd0, 16'h0, 32'd5, 32'd6);
    send(4'h0, 4'h0, 1'b0, 3'd0, 5'd0, 16'h0, 32'd1, 32'd2);
    send(4'h7, 4'hE, 1'b0, 3'd4, 5'd4, 16'h0, 32'h0, 32'h80000000);
    send(4'h7, 4'hE, 1'b0, 3'd3, 5'd4, 16'h0, 32'h0, 32'h0000000F);
    // Zero shift amount in every mode, immediate move, LDR/STR, NOP, NV, illegal op and shift.
    for (int m = 0; m <= 4; m++)
      send(4'h7, 4'hE, 1'b1, 3'(m), 5'd0, 16'h0, 32'h0, 32'h8000_00F1);
    send(4'h6, 4'hE, 1'b1, 3'd0, 5'd0, 16'hABCD, 32'h0, 32'h0);
    send(4'h9, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'h1234_5678, 32'h9);
    send(4'hA, 4'hE, 1'b1, 3'd2, 5'd8, 16'h0, 32'h0, 32'h00AB_CDEF);
    send(4'hF, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'h1, 32'h1);
    send(4'h0, 4'hF, 1'b1, 3'd0, 5'd0, 16'h0, 32'h1, 32'h1);
    send(4'hC, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'h1, 32'h1);
    send(4'h0, 4'hE, 1'b1, 3'd5, 5'd1, 16'h0, 32'h1, 32'h1);
    send(4'h1, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'h8000_0000, 32'h1);

    // Output stall: RESULT must hold and new work must be refused.
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    send(4'h0, 4'hE, 1'b0, 3'd0, 5'd0, 16'h0, 32'd3, 32'd4);
    fork
      send(4'h0, 4'hE, 1'b0, 3'd0, 5'd0, 16'h0, 32'd1, 32'd1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge CLK);
          chk_eq($sformatf("stall_in_ready%0d", i), IN_READY, 0);
          chk_eq($sformatf("stall_result%0d", i), RESULT, 32'd7);
          chk_eq($sformatf("stall_valid%0d", i), OUT_VALID, 1);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
      end
    join

    // Multiply latency and back-pressure on the input.
    send(4'h2, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'h10000, 32'h30000);
    lat = 0;
    while (!OUT_VALID && lat < 100) begin
      @(negedge CLK);
      if (!OUT_VALID) begin
        lat++;
        chk_eq($sformatf("mul_in_ready%0d", lat), IN_READY, 0);
      end
    end
    chk_eq("mul_latency", lat, 33);
    @(posedge CLK); #1;

    // Randomised instruction stream with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          r_op = 4'($urandom_range(0, 15));
          r_a  = $urandom;
          send(r_op, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 5)), 5'($urandom_range(0, 31)), 16'($urandom),
               r_a, ($urandom_range(0, 3) == 0) ? r_a : 32'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK); #1;
          OUT_READY = ($urandom_range(0, 3) != 0);
        end
        OUT_READY = 1'b1;
      end
    join

    // Reset in the middle of a multiply: no result may ever appear for it.
    send(4'h2, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'hFFFF, 32'hFFFF);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk_eq("abort_out_valid", OUT_VALID, 0);
    chk_eq("abort_nzcv", NZCV, 0);
    chk_eq("abort_in_ready", IN_READY, 1);
    qn = sb_q.size();
    chk_eq("abort_pending", qn, 1);
    sb_q.delete();
    m_nzcv = 4'h0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (OUT_VALID) seen++;
    end
    chk_eq("abort_no_output", seen, 0);
    @(posedge CLK); #1;

    send(4'h0, 4'hE, 1'b1, 3'd0, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1);
    qn = 0;
    while (sb_q.size() != 0 && qn < 100) begin
      @(posedge CLK);
      qn++;
    end
    qn = sb_q.size();
    chk_eq("drain", qn, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_n.md
Name: alu_seq_n

Overview:
- Parametrised, clocked successor to the 32-bit combinational ALU. Executes one instruction per valid/ready transaction: ADD, SUB, MUL, ORR, AND, EOR, MOV, CMP, LDR, STR and NOP.
- Keeps an internal NZCV flags register and gates each instruction on a 4-bit condition code.
- Adds an iterative multi-cycle multiplier, an arithmetic-shift-right mode, an output hold buffer and an illegal-instruction indication.
- Sits between the decode stage and the register-file/memory writeback stage.

Parameters:
WIDTH, 32, datapath width in bits; legal values are 8 to 64.
IMM_W, 16, immediate field width; the immediate is zero-extended to WIDTH; must be ≤ WIDTH.
SHW, $clog2(WIDTH), width of the shift/rotate amount field.

Ports:
CLK  input  1  clock, rising-edge active.
RESET  input  1  asynchronous, active-low reset.
IN_VALID  input  1  instruction valid.
IN_READY  output  1  block can accept an instruction.
OPCODE  input  4  0000 ADD, 0001 SUB, 0010 MUL, 0011 ORR, 0100 AND, 0101 EOR, 0110 MOV imm, 0111 MOV reg, 1000 CMP, 1001 LDR, 1010 STR, 1111 NOP.
COND  input  4  ARM condition encoding: 0000 EQ through 1101 LE, 1110 AL; 1111 is treated as never.
S  input  1  set flags.
SHIFT_CTRL  input  3  operand-2 shift: 000 none, 001 LSR, 010 LSL, 011 ROR, 100 ASR.
SHAMT  input  SHW  shift/rotate amount.
IM_VAL  input  IMM_W  immediate value.
SR1  input  WIDTH  source operand 1.
SR2  input  WIDTH  source operand 2, before shifting.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  downstream accepts the result.
RESULT  output  WIDTH  operation result.
WB_EN  output  1  result must be written back; qualified by OUT_VALID.
CND_MET  output  1  condition outcome of the instruction currently on the output.
ILLEGAL  output  1  instruction on the output had an invalid OPCODE or SHIFT_CTRL.
NZCV  output  4  current committed flags.

Behaviour:
- Reset (RESET low, asynchronous):
  - state IDLE; NZCV=0000; RESULT=0; OUT_VALID, WB_EN, CND_MET and ILLEGAL all 0.
  - Multiplier counter, accumulator and captured operands are cleared.
  - Reset asserted mid-multiply aborts the multiply; no result is ever emitted for it.
- States:
  - IDLE: no result held.
  - MUL: multiply in progress.
  - HOLD: OUT_VALID=1, waiting for OUT_READY.
- IN_READY = (state==IDLE) | (state==HOLD & OUT_READY).
  - This allows back-to-back single-cycle instructions at one per clock when OUT_READY is held high.
  - A transaction is accepted on a rising edge where IN_VALID & IN_READY.
- Condition:
  - Evaluated at acceptance against the committed NZCV.
  - Because flags commit when a result is produced, the following instruction always sees the previous instruction's flags.
- Condition failed, NOP, or illegal instruction:
  - Goes to HOLD the next cycle with RESULT=0, WB_EN=0 and flags unchanged.
  - CND_MET reports the evaluated condition. ILLEGAL=1 for an invalid OPCODE or SHIFT_CTRL 101–111.
- Single-cycle operations (all except MUL):
  - The result is registered at acceptance; OUT_VALID rises the next cycle, giving latency 1.
  - WB_EN=1 except for CMP and NOP.
  - LDR passes SR1 (address); STR passes the shifted SR2.
- MUL:
  - Enters MUL, then performs unsigned shift-add, one bit per cycle, for WIDTH cycles.
  - OUT_VALID rises WIDTH+1 cycles after acceptance.
  - IN_READY=0 throughout the multiply.
- Shifts:
  - Applied to SR2 before every operation except MOV imm.
  - SHAMT=0 leaves SR2 unchanged for every mode.
  - ROR wraps modulo WIDTH. ASR replicates SR2[WIDTH-1].
- Flags:
  - Written in the same cycle RESULT is registered, only when (S | OPCODE==CMP), the condition passed, and the instruction is legal.
  - N = RESULT[WIDTH-1]; Z = (RESULT==0).
  - ADD: C = carry-out; V = (a and b have the same sign) & (sum sign differs from a).
  - SUB/CMP: computed as a + ~b + 1; C = no-borrow; V = (a and b have differing signs) & (result sign differs from a).
  - MUL: C=0; V=1 if the upper WIDTH bits of the 2·WIDTH-bit product are nonzero.
  - Logic ops and MOV: C=0, V=0. LDR/STR never write flags.
- HOLD with OUT_READY=0: RESULT, WB_EN, CND_MET and ILLEGAL stay stable; IN_READY=0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD … OP_NOP;
  - condition-code localparams;
  - shift-mode localparams;
  - flag bit indices: N=3, Z=2, C=1, V=0.
- One sub-module, alu_cond_eval: combinational COND×NZCV → met.
- The multiplier stays inline in the main module.

Test Plan:
- After reset release, ADD with SR1=0x7FFFFFFF, SR2=1, S=1, COND=AL, OUT_READY=1 -> one cycle later RESULT=0x80000000, NZCV=1001, WB_EN=1.
- CMP 5,5 then SUB with COND=EQ (SR1=9, SR2=4) -> CMP gives NZCV=0110, WB_EN=0; SUB gives RESULT=5, CND_MET=1.
- CMP 5,6 then ADD with COND=EQ -> CND_MET=0, RESULT=0, WB_EN=0, NZCV stays 1000.
- MUL with SR1=0x10000, SR2=0x30000, S=1 -> OUT_VALID exactly 33 cycles after acceptance, IN_READY=0 meanwhile, RESULT=0, NZCV=0101.
- MOV reg with SR2=0x80000000, SHIFT_CTRL=ASR, SHAMT=4 -> RESULT=0xF8000000; repeat with ROR, SHAMT=4, SR2=0x0000000F -> RESULT=0xF0000000.
- OUT_READY held low for 5 cycles with IN_VALID high -> RESULT stable and IN_READY=0; RESET pulsed during MUL -> OUT_VALID=0 and NZCV=0000 immediately, no result emitted.
